// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and trigger-match rule for the capture
// sequencer. The match function works on a fixed maximum width so that any
// sample width up to TRIG_MAX_W can reuse it via zero extension.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } cap_state_t;

  localparam int TRIG_MAX_W = 64;

  // Level bits must equal value; edge bits must equal value and differ from
  // the previous sample. Bits outside the mask never block a match.
  function automatic logic trig_hit(
    input logic [TRIG_MAX_W-1:0] sample,
    input logic [TRIG_MAX_W-1:0] prev,
    input logic [TRIG_MAX_W-1:0] mask,
    input logic [TRIG_MAX_W-1:0] value,
    input logic [TRIG_MAX_W-1:0] edge_sel
  );
    logic [TRIG_MAX_W-1:0] diff_val;
    logic [TRIG_MAX_W-1:0] level_miss;
    logic [TRIG_MAX_W-1:0] edge_miss;
    diff_val   = sample ^ value;
    level_miss = diff_val & mask & ~edge_sel;
    edge_miss  = (diff_val | ~(sample ^ prev)) & mask & edge_sel;
    return ((level_miss | edge_miss) == '0);
  endfunction

endpackage

// File: rtl/trig_match.sv
// trig_match: purely combinational trigger comparator. An edge bit whose
// prev equals sample can never match, which is how the caller expresses
// "no valid previous sample".
module trig_match
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] prev,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] edge_sel,
  output logic                  match
);

  assign match = trig_hit(TRIG_MAX_W'(sample), TRIG_MAX_W'(prev),
                          TRIG_MAX_W'(mask), TRIG_MAX_W'(value),
                          TRIG_MAX_W'(edge_sel));

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture-buffer sequencer for the logic analyzer. Writes
// qualified samples into a circular buffer, keeps pretrig_depth samples ahead
// of the trigger and reports trigger / oldest-sample addresses when done.
// Optional feature macro: CAPTURE_EDGE_TRIG_EN adds edge-qualified trigger
// bits (previous-sample register); without it the trigger is level-only.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [ADDR_WIDTH-1:0] pretrig_depth,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_edge,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  cap_state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] cfg_depth;
  logic [ADDR_WIDTH-1:0] post_load;
  logic [DATA_WIDTH-1:0] cfg_mask;
  logic [DATA_WIDTH-1:0] cfg_value;
  logic [DATA_WIDTH-1:0] prev_eff;
  logic [DATA_WIDTH-1:0] edge_eff;
  logic                  in_capture;
  logic                  wr_fire;
  logic                  load_cfg;
  logic                  hit;

  // Samples still to write after the trigger: N-1-depth, i.e. ~depth.
  assign post_load = ~cfg_depth;

`ifdef CAPTURE_EDGE_TRIG_EN
  logic [DATA_WIDTH-1:0] cfg_edge;
  logic [DATA_WIDTH-1:0] prev_smp;
  logic                  prev_vld;

  // Latch edge selects on arm and track the last written sample for edge bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_edge <= '0;
      prev_smp <= '0;
      prev_vld <= 1'b0;
    end else if (load_cfg) begin
      cfg_edge <= trig_edge;
      prev_vld <= 1'b0;
    end else if (wr_fire) begin
      prev_smp <= sample_in;
      prev_vld <= 1'b1;
    end
  end

  // Without a valid previous sample, feed the sample itself so no edge matches.
  assign edge_eff = cfg_edge;
  assign prev_eff = prev_vld ? prev_smp : sample_in;
`else
  logic unused_edge;
  assign unused_edge = ^trig_edge;
  assign edge_eff    = '0;
  assign prev_eff    = sample_in;
`endif

  trig_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig_match (
    .sample  (sample_in),
    .prev    (prev_eff),
    .mask    (cfg_mask),
    .value   (cfg_value),
    .edge_sel(edge_eff),
    .match   (hit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; abort dominates arm and any in-flight sample
  always_comb begin
    state_nx   = state;
    load_cfg   = 1'b0;
    in_capture = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    wr_fire    = sample_en && in_capture && !abort;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            load_cfg = 1'b1;
            state_nx = (pretrig_depth == '0) ? WAIT_TRIG : PRE;
          end
        end
        PRE: begin
          if (sample_en && ((pre_cnt + ADDR_ONE) == cfg_depth)) begin
            state_nx = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (sample_en && hit) begin
            state_nx = (post_load == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (sample_en && (post_cnt == ADDR_ONE)) begin
            state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Write port, pointer/counters, configuration and result addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      cfg_depth   <= '0;
      cfg_mask    <= '0;
      cfg_value   <= '0;
      trig_addr   <= '0;
      start_addr  <= '0;
    end else begin
      buf_wr_en <= wr_fire;
      if (load_cfg) begin
        wr_ptr     <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        cfg_depth  <= pretrig_depth;
        cfg_mask   <= trig_mask;
        cfg_value  <= trig_value;
        trig_addr  <= '0;
        start_addr <= '0;
      end
      if (abort) begin
        trig_addr  <= '0;
        start_addr <= '0;
      end
      if (wr_fire) begin
        buf_wr_addr <= wr_ptr;
        buf_wr_data <= sample_in;
        wr_ptr      <= wr_ptr + ADDR_ONE;
        case (state)
          PRE: pre_cnt <= pre_cnt + ADDR_ONE;
          WAIT_TRIG: begin
            if (hit) begin
              trig_addr <= wr_ptr;
              post_cnt  <= post_load;
              if (post_load == '0) begin
                start_addr <= wr_ptr - cfg_depth;
              end
            end
          end
          POST: begin
            post_cnt <= post_cnt - ADDR_ONE;
            if (post_cnt == ADDR_ONE) begin
              start_addr <= trig_addr - cfg_depth;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = in_capture;
  assign done = (state == DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven and randomized checks of capture_ctrl with
// ADDR_WIDTH=4 (N=16). Expected behaviour comes from a sample-stream model:
// sample k goes to address k mod N, the trigger is the first k >= depth that
// matches, and the capture ends after k + N - depth writes.
module tb_capture_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int N    = 16;
  localparam int MAXS = 96;

`ifdef CAPTURE_EDGE_TRIG_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct {
    int          depth;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic [7:0]  edgem;
    int          en_per;
    int          mode;
    int          arm_at;
    int          exp_trig;
    int          exp_start;
    int          exp_w;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [AW-1:0] pretrig_depth = '0;
  logic [DW-1:0] trig_mask = '0;
  logic [DW-1:0] trig_value = '0;
  logic [DW-1:0] trig_edge = '0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] smp [0:MAXS+N-1];
  rec_t vec[$];

  capture_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .sample_en    (sample_en),
    .sample_in    (sample_in),
    .pretrig_depth(pretrig_depth),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .trig_edge    (trig_edge),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .buf_wr_data  (buf_wr_data),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr),
    .start_addr   (start_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // mode 0: counter, 1: square wave on bit 0 (1,1,0,0,...), 2: random
  task automatic fill_samples(input int mode);
    for (int i = 0; i < MAXS + N; i++) begin
      case (mode)
        0:       smp[i] = 8'(i);
        1:       smp[i] = (((i >> 1) & 1) == 0) ? 8'h01 : 8'h00;
        default: smp[i] = 8'($urandom);
      endcase
    end
  endtask

  // Index of the trigger sample in the stream, or -1 within MAXS samples.
  function automatic int model_trig(input int depth, input logic [7:0] mask,
                                    input logic [7:0] value, input logic [7:0] edgem);
    for (int k = depth; k < MAXS; k++) begin
      bit ok;
      ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) begin
          if (EDGE_EN && edgem[b]) begin
            if (k == 0) ok = 1'b0;
            else if (smp[k][b] == smp[k-1][b] || smp[k][b] != value[b]) ok = 1'b0;
          end else if (smp[k][b] != value[b]) begin
            ok = 1'b0;
          end
        end
      end
      if (ok) return k;
    end
    return -1;
  endfunction

  task automatic run_capture(input int depth, input logic [7:0] mask, input logic [7:0] value,
                             input logic [7:0] edgem, input int en_per, input int arm_at,
                             input int exp_trig, input int exp_start, input int exp_w,
                             input string tag);
    int idx, nwr_obs, en_cnt, cyc, budget, bad;
    logic en, exp_wr, fin;
    logic [7:0] mem [0:N-1];
    for (int j = 0; j < N; j++) mem[j] = '0;
    @(negedge clk);
    pretrig_depth = 4'(depth);
    trig_mask     = mask;
    trig_value    = value;
    trig_edge     = edgem;
    sample_en     = 1'b0;
    arm           = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    idx = 0; nwr_obs = 0; en_cnt = 0; cyc = 0; fin = 1'b0;
    if (exp_w >= 0) budget = (exp_w + 2) * ((en_per == 0) ? 8 : en_per) + 8;
    else            budget = MAXS * 8 + 8;
    while (!fin && cyc < budget) begin
      if (en_per == 0) en = 1'($urandom_range(0, 1));
      else             en = ((cyc % en_per) == 0);
      sample_en = en;
      sample_in = en ? smp[idx] : 8'($urandom);
      if (cyc == arm_at) begin
        arm           = 1'b1;
        pretrig_depth = '0;
        trig_mask     = '0;
      end
      @(negedge clk);
      arm = 1'b0;
      exp_wr = en && ((exp_w < 0) || (idx < exp_w));
      if (exp_wr) en_cnt++;
      if (buf_wr_en) begin
        nwr_obs++;
        mem[buf_wr_addr] = buf_wr_data;
      end
      chk({tag, ".wr_en"}, buf_wr_en, exp_wr);
      if (exp_wr) begin
        chk({tag, ".addr"}, buf_wr_addr, idx % N);
        chk({tag, ".data"}, buf_wr_data, smp[idx]);
        idx++;
      end
      chk({tag, ".done"}, done, (exp_w >= 0) && (idx == exp_w));
      chk({tag, ".busy"}, busy, !((exp_w >= 0) && (idx == exp_w)));
      if (exp_w >= 0 && idx == exp_w) fin = 1'b1;
      if (exp_w < 0 && idx >= MAXS) fin = 1'b1;
      cyc++;
    end
    sample_en = 1'b0;
    chk({tag, ".finished_in_budget"}, fin, 1'b1);
    chk({tag, ".wr_count"}, nwr_obs, en_cnt);
    if (fin && exp_w >= 0) begin
      chk({tag, ".trig_addr"}, trig_addr, exp_trig);
      chk({tag, ".start_addr"}, start_addr, exp_start);
      bad = 0;
      for (int j = 0; j < N; j++) begin
        if (mem[(exp_start + j) % N] !== smp[exp_w - N + j]) bad++;
      end
      chk({tag, ".readout_bad"}, bad, 0);
      for (int j = 0; j < 3; j++) begin
        sample_en = 1'b1;
        sample_in = 8'($urandom);
        @(negedge clk);
        chk({tag, ".hold_wr_en"}, buf_wr_en, 1'b0);
        chk({tag, ".hold_done"}, done, 1'b1);
      end
      sample_en = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({tag, ".idle_after_abort"}, {busy, done}, 2'b00);
  endtask

  initial begin
    // depth mask value edge en_per mode arm_at | trig start writes
    vec.push_back('{4,  8'hFF, 8'h0A, 8'h00, 1, 0, -1, 10, 6, 22});
    vec.push_back('{0,  8'hFF, 8'h03, 8'h00, 1, 0, -1,  3, 3, 19});
    vec.push_back('{15, 8'hFF, 8'h14, 8'h00, 1, 0, -1,  4, 5, 21});
    vec.push_back('{4,  8'hFF, 8'h0A, 8'h00, 3, 0, -1, 10, 6, 22});
    vec.push_back('{4,  8'hFF, 8'h0A, 8'h00, 1, 0,  6, 10, 6, 22});
    vec.push_back('{5,  8'h00, 8'h00, 8'h00, 1, 0, -1,  5, 0, 16});
`ifdef CAPTURE_EDGE_TRIG_EN
    vec.push_back('{0,  8'h01, 8'h01, 8'h01, 1, 1, -1,  4, 4, 20});
    vec.push_back('{3,  8'h01, 8'h01, 8'h01, 1, 1, -1,  4, 1, 17});
`else
    vec.push_back('{0,  8'h01, 8'h01, 8'h01, 1, 1, -1,  0, 0, 16});
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset.wr_en", buf_wr_en, 1'b0);
    chk("reset.addr", buf_wr_addr, 4'h0);
    chk("reset.data", buf_wr_data, 8'h00);
    chk("reset.busy_done", {busy, done}, 2'b00);
    chk("reset.trig_start", {trig_addr, start_addr}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      fill_samples(vec[i].mode);
      run_capture(vec[i].depth, vec[i].mask, vec[i].value, vec[i].edgem, vec[i].en_per,
                  vec[i].arm_at, vec[i].exp_trig, vec[i].exp_start, vec[i].exp_w,
                  $sformatf("vec%0d", i));
    end

    repeat (8) begin
      int d, k, w;
      logic [7:0] m, v, e;
      d = $urandom_range(0, 15);
      m = 8'($urandom) & 8'($urandom) & 8'($urandom);
      v = 8'($urandom);
      e = 8'($urandom);
      fill_samples(2);
      k = model_trig(d, m, v, e);
      w = (k < 0) ? -1 : (k + N - d);
      run_capture(d, m, v, e, 0, -1, (k < 0) ? 0 : (k % N),
                  (k < 0) ? 0 : ((k - d + N) % N), w, "rand");
    end

    // abort during POST
    fill_samples(0);
    @(negedge clk);
    pretrig_depth = 4'd4; trig_mask = 8'hFF; trig_value = 8'h0A; trig_edge = 8'h00;
    arm = 1'b1; sample_en = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 14; i++) begin
      sample_en = 1'b1; sample_in = smp[i];
      @(negedge clk);
    end
    chk("abort.pre_trig_addr", trig_addr, 4'd10);
    chk("abort.pre_busy", busy, 1'b1);
    abort = 1'b1; sample_en = 1'b1; sample_in = smp[14];
    @(negedge clk);
    abort = 1'b0;
    chk("abort.wr_en", buf_wr_en, 1'b0);
    chk("abort.busy_done", {busy, done}, 2'b00);
    chk("abort.trig_start", {trig_addr, start_addr}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; sample_in = smp[15 + i];
      @(negedge clk);
      chk("abort.no_write", buf_wr_en, 1'b0);
    end
    sample_en = 1'b0;

    // arm and abort together from DONE resolve to IDLE
    @(negedge clk);
    pretrig_depth = 4'd0; trig_mask = 8'h00; trig_value = 8'h00;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample_en = 1'b1; sample_in = smp[i];
      @(negedge clk);
    end
    chk("armabort.done_before", done, 1'b1);
    arm = 1'b1; abort = 1'b1; sample_en = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    chk("armabort.busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    chk("armabort.no_write", buf_wr_en, 1'b0);
    sample_en = 1'b0;

    // asynchronous reset mid-capture
    @(negedge clk);
    pretrig_depth = 4'd4; trig_mask = 8'hFF; trig_value = 8'h0A;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1; sample_in = smp[i];
      @(negedge clk);
    end
    chk("rst.pre_addr", buf_wr_addr, 4'd7);
    #2 rst = 1'b1;
    #1;
    chk("rst.wr_en", buf_wr_en, 1'b0);
    chk("rst.addr_data", {buf_wr_addr, buf_wr_data}, 12'h000);
    chk("rst.busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.after_wr_en_busy", {buf_wr_en, busy}, 2'b00);
    sample_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencing controller for the logic analyzer's capture buffer. It qualifies incoming samples, evaluates the trigger condition and produces the write strobe, address and data for the dual-port sample RAM. Addressing is circular, so the buffer holds a programmable number of pre-trigger samples. When capture completes it reports the trigger address and the oldest-sample address to the readout side.

## Interface
- DATA_WIDTH, 8: sample width in bits.
- ADDR_WIDTH, 11: buffer address width; depth N = 2^ADDR_WIDTH.

- clk  in  1  single clock; drives this block and the buffer write port.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE.
- abort  in  1  one-cycle pulse; returns to IDLE from any state; highest priority.
- sample_en  in  1  sample-valid strobe from the sampling clock-enable.
- sample_in  in  DATA_WIDTH  probe data; valid when sample_en=1.
- pretrig_depth  in  ADDR_WIDTH  number of samples kept before the trigger, 0..N-1; latched on arm.
- trig_mask  in  DATA_WIDTH  1 = bit participates in the trigger; latched on arm.
- trig_value  in  DATA_WIDTH  required bit level (or post-edge level); latched on arm.
- trig_edge  in  DATA_WIDTH  1 = bit is an edge condition; latched on arm; ignored unless CAPTURE_EDGE_TRIG_EN.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  ADDR_WIDTH  buffer write address.
- buf_wr_data  out  DATA_WIDTH  buffer write data.
- busy  out  1  1 in PRE, WAIT_TRIG and POST.
- done  out  1  level; 1 in DONE.
- trig_addr  out  ADDR_WIDTH  address of the trigger sample; valid when done=1.
- start_addr  out  ADDR_WIDTH  address of the oldest sample, equal to (trig_addr - pretrig_depth) mod N; valid when done=1.

## Operation
- **States:** IDLE, PRE, WAIT_TRIG, POST, DONE.
- **Reset:** state=IDLE. All outputs and counters are 0.
- **IDLE/DONE + arm:**
  - Clear the write pointer and the pre/post counters.
  - Latch the configuration.
  - Go to PRE, or to WAIT_TRIG if pretrig_depth=0.
- **arm in other states:** arm while busy is ignored.
- **Writing:** every sample_en in PRE, WAIT_TRIG or POST writes sample_in at the write pointer. The pointer then increments modulo N, wrapping N-1 -> 0.
- **PRE:**
  - Counts writes.
  - After pretrig_depth writes, go to WAIT_TRIG.
  - The trigger is not evaluated in PRE.
- **WAIT_TRIG:**
  - Evaluate the trigger on each sample_en.
  - On a match: the matching sample is written, trig_addr takes that sample's address, and the post counter loads N-1-pretrig_depth.
  - Next state is POST, or DONE if the loaded count is 0.
  - Without a match, writing continues indefinitely and overwrites older samples.
- **POST:**
  - Each write decrements the post counter.
  - The write that takes it to 0 moves to DONE.
  - start_addr is computed on the DONE transition.
- **DONE:** no writes; outputs hold until arm, abort or rst.
- **Level trigger:** match when ((sample_in ^ trig_value) & trig_mask) == 0. A mask of 0 triggers on the first WAIT_TRIG sample.
- **abort:**
  - Goes to IDLE with no further writes.
  - done=0; trig_addr and start_addr are cleared.
  - abort and arm in the same cycle resolve to IDLE.
- **Width rules:**
  - Address arithmetic is ADDR_WIDTH-bit unsigned modular.
  - The post counter is ADDR_WIDTH bits.

## Timing
- One cycle of latency: a sample_en in cycle t gives buf_wr_en=1 in cycle t+1, with buf_wr_addr and buf_wr_data registered.
- buf_wr_en is 0 in any cycle not following a qualified sample_en.
- State transitions take effect in the cycle after the deciding sample_en.
- done rises in the same cycle as the final buf_wr_en. trig_addr and start_addr are stable from that cycle.
- sample_en may be asserted every cycle; throughput is one sample per clock.
- Asynchronous rst mid-capture: outputs go to 0 immediately. The partial buffer contents are undefined to the readout side.

## Configuration
- **CAPTURE_EDGE_TRIG_EN defined:**
  - A previous-sample register is added, updated on each sample_en while busy.
  - For bits with trig_edge=1 and trig_mask=1, a match requires prev != sample_in and sample_in == trig_value (rising or falling edge chosen by trig_value).
  - Bits with trig_mask=1 and trig_edge=0 keep the level rule.
  - The first sample after arm has no valid previous sample, so it cannot match an edge bit.
- **Undefined:** trig_edge is ignored and the trigger is level-only. The port still exists.

## Structure
- **Shared package** (capture_pkg):
  - State enum: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4, 3-bit encoding.
  - The trigger-match function.
- **Sub-module:** trig_match, a combinational comparator taking sample, prev, mask, value and edge and producing match.
- **Top level:** capture_ctrl is instantiated next to the sample buffer; its buf_wr_* outputs connect to the buffer's write port.

## Test plan
All cases use ADDR_WIDTH=4 (N=16), sample_en=1 every cycle and sample_in = 0,1,2,… unless stated otherwise.
- **Basic capture:** pretrig_depth=4, mask=0xFF, value=0x0A.
  - trig_addr=10, done after 22 writes.
  - Final write addr=5; start_addr=6.
  - Reading from address 6 gives 6..21.
- **Zero pre-trigger:** pretrig_depth=0, value=0x03.
  - Goes directly to WAIT_TRIG; trig_addr=3.
  - 15 post writes; start_addr=3.
- **Full pre-trigger:** pretrig_depth=15, value=0x14.
  - done in the cycle of the trigger write, with no POST.
  - trig_addr=4, start_addr=5.
- **Gated sampling:** sample_en asserted on every 3rd cycle.
  - Write addresses are still consecutive.
  - buf_wr_en count equals the sample_en count.
- **Control:**
  - abort during POST -> IDLE, no further buf_wr_en, done=0.
  - arm during busy is ignored.
  - rst mid-capture clears all outputs asynchronously.
- **Edge trigger (CAPTURE_EDGE_TRIG_EN):** square wave on bit 0, mask=0x01, edge=0x01, value=0x01.
  - Triggers on the first 0->1 transition after PRE.
  - A first sample already at 1 does not trigger.
